mips_multicycle: RTL and testbench
==================================

Name: mips_multicycle

Overview:
- Multi-cycle successor to the single-cycle MIPS top.
- Runs one instruction at a time through a FETCH/DECODE/EXEC/MEM/WB state machine, with an internal 32x32 register file.
- Uses a single shared memory port with a req/ack handshake, so instruction and data memory may have wait states.
- Adds an illegal-opcode halt, a retire pulse and a retired-instruction counter for the bench and for later pipeline comparison.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- MEM_ADDR_W, 10: memory word-address width; mem_addr = byte address [MEM_ADDR_W+1:2].
- PERF_CNT_W, 32: width of retire_cnt.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request; held until ack.
- mem_we  out  1  1=write (sw), 0=read; valid while mem_req=1.
- mem_addr  out  MEM_ADDR_W  word address; stable while mem_req=1.
- mem_wdata  out  32  store data; stable while mem_req=1 and mem_we=1.
- mem_ack  in  1  access complete this cycle; may be high in the same cycle req rises.
- mem_rdata  in  32  read data, sampled in the ack cycle.
- pc_o  out  32  PC of the instruction currently executing.
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
- retire_cnt  out  PERF_CNT_W  count of retired instructions; wraps at 2^PERF_CNT_W.
- halted  out  1  core stopped on an illegal instruction.

Behaviour:
- Reset (rst=1 at edge):
  - Clocking: one clock, clk; reset is synchronous and active-high on rst.
  - State values: state=FETCH, PC=RESET_PC, retire_cnt=0, halted=0.
  - Outputs during reset: mem_req=0, mem_we=0, retire=0.
  - Register file contents are not cleared.
  - Reset overrides everything, including an outstanding mem_req: the request drops the next cycle and a late ack is ignored.
- Supported instructions:
  - R-type (op 0): addu 21, subu 23, and 24, or 25, slt 2A (signed).
  - Immediate: addiu 09 (sign-extended), ori 0D (zero-extended), lui 0F (imm<<16).
  - Memory: lw 23, sw 2B (sign-extended offset).
  - Control: beq 04 (target = PC+4 + sext(imm)<<2), j 02 (target = {PC+4[31:28], imm26, 2'b00}).
  - Any other op or funct is illegal.
- Arithmetic: all ALU arithmetic is 32-bit modulo; no overflow traps.
- Register $0: always reads 0; writes to it are discarded.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=PC word address.
  - On mem_ack: IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - Without ack: stay in FETCH with all outputs held.
- DECODE:
  - Latch A=RF[rs], B=RF[rt] and the extended immediate.
  - j: PC<=target, retire, go to FETCH.
  - Illegal: go to HALT with no retire.
  - Otherwise go to EXEC.
- EXEC:
  - ALU result latched into ALUOut.
  - beq: if A==B then PC<=target; retire; go to FETCH.
  - lw/sw go to MEM; other instructions go to WB.
- MEM:
  - mem_req=1, mem_addr=ALUOut word address; the low two address bits are ignored.
  - sw: mem_we=1, mem_wdata=B; retire on ack, then FETCH.
  - lw: mem_we=0; MDR<=mem_rdata on ack, then WB.
- WB:
  - Write RF[rd] for R-type, RF[rt] for I-type/lw; data is ALUOut or MDR.
  - Retire, then FETCH.
- HALT:
  - Terminal state: halted=1, mem_req=0; only rst exits it.
  - pc_o holds the illegal instruction's PC (PC-4 of the incremented PC).
- Latency with zero-wait memory (ack in the request cycle):
  - j: 2 cycles.
  - beq: 3 cycles.
  - ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory wait cycle adds 1.
- retire_cnt: increments in the same cycle retire=1; visible the next cycle.
- Read-after-write: a write in WB is visible to the next instruction's DECODE; no bypass is needed.

Test Plan:
- Reset then zero-wait memory, program "ori $1,$0,5; ori $2,$0,3; addu $3,$1,$2; subu $4,$2,$1" -> $3=8, $4=32'hFFFF_FFFE, retire_cnt=4 after 16 cycles.
- lw/sw: "sw $3,8($0); lw $5,8($0)" -> one write with mem_addr=2 and mem_wdata=8, then $5=8; with 3 ack-wait cycles per access the lw takes 5+3+3 cycles and mem_addr/mem_we stay stable while waiting.
- beq taken (A==B, imm=-1) -> PC loops to the same address, 3 cycles per iteration; not-taken -> PC advances by 4.
- j to 0x0000_0040 -> next fetch mem_addr=16; 2-cycle latency; "addu $0,$1,$1" leaves $0 reading 0.
- Opcode 6'h3F at PC=0x0C -> halted=1 two cycles after the fetch ack, pc_o=0x0C, no retire, mem_req stays 0; rst then restarts at RESET_PC.
- Assert rst while FETCH waits on ack -> next cycle mem_req=0, PC=RESET_PC, retire_cnt=0; an ack arriving during reset has no effect.

Source files
------------

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared
// req/ack memory port, with an illegal-instruction halt and a retired-instruction counter.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_ADDR_W = 10,
  parameter int unsigned PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           pc_o,
  output logic                  retire,
  output logic [PERF_CNT_W-1:0] retire_cnt,
  output logic                  halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [31:0] pc, cur_pc, ir, a, b, imm_ext, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wb_reg;
  logic [15:0] imm16;
  logic [31:0] rs_val, rt_val, imm_next, alu_res, j_target, br_target, wb_data;
  logic        legal;
  logic        unused_shamt;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm16  = ir[15:0];
  assign unused_shamt = ^ir[10:6];

  // $0 is never written, so reading it must be forced to zero here.
  assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf[rt];

  // pc already holds PC+4 once the fetch has completed.
  assign j_target  = {pc[31:28], ir[25:0], 2'b00};
  assign br_target = pc + {imm_ext[29:0], 2'b00};

  assign wb_reg  = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_out;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
          default:                                 legal = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_next = {{16{imm16[15]}}, imm16};
    case (op)
      OP_ORI:  imm_next = {16'h0000, imm16};
      OP_LUI:  imm_next = {imm16, 16'h0000};
      default: imm_next = {{16{imm16[15]}}, imm16};
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: alu_res = a + b;
          FN_SUBU: alu_res = a - b;
          FN_AND:  alu_res = a & b;
          FN_OR:   alu_res = a | b;
          FN_SLT:  alu_res = {31'b0, ($signed(a) < $signed(b))};
          default: alu_res = '0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alu_res = a + imm_ext;
      OP_ORI:                 alu_res = a | imm_ext;
      OP_LUI:                 alu_res = imm_ext;
      default:                alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc[MEM_ADDR_W+1:2];
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          state_next = S_HALT;
        end else if (op == OP_J) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_BEQ) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = alu_out[MEM_ADDR_W+1:2];
        if (mem_ack) begin
          if (op == OP_SW) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    // Reset must silence the port in the same cycle, even mid-request.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      retire_cnt <= '0;
    end else begin
      state <= state_next;
      if (retire) retire_cnt <= retire_cnt + PERF_CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir     <= mem_rdata;
            cur_pc <= pc;
            pc     <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          imm_ext <= imm_next;
          if (legal && op == OP_J) pc <= j_target;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (op == OP_BEQ && a == b) pc <= br_target;
        end
        S_MEM: begin
          if (mem_ack && op == OP_LW) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_WB && wb_reg != 5'd0) rf[wb_reg] <= wb_data;
  end

  assign mem_wdata = b;
  assign pc_o      = (state == S_FETCH) ? pc : cur_pc;
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench: an ISA-level reference interpreter predicts retires and stores,
// a wait-state memory model serves the core, and a monitor checks each retire.
module tb_mips_multicycle;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ack, retire, halted;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, pc_o, retire_cnt;

  always #5 clk = ~clk;

  mips_multicycle #(.RESET_PC(RESET_PC), .MEM_ADDR_W(10), .PERF_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc_o(pc_o),
    .retire(retire), .retire_cnt(retire_cnt), .halted(halted)
  );

  typedef struct { logic [31:0] pc; int lat; int cnt; } ret_t;
  typedef struct { logic [9:0] addr; logic [31:0] data; } st_t;

  ret_t        ret_q[$];
  st_t         st_q[$];
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int          total = 0, bad = 0;
  int          mem_mode = 0, max_wait = 0;
  int          gcyc = 0, last_rd_ack = 0;
  logic [31:0] exp_halt_pc;
  int          exp_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(int word);
    return {6'h02, 26'(word)};
  endfunction

  // ISA interpreter: predicted retires (pc, base latency, index) and stores.
  task automatic ref_run();
    logic [31:0] r [32];
    logic [31:0] pcv, npc, ins, sx, v, ea;
    bit ill;
    int lat;
    for (int i = 0; i < 32; i++) r[i] = '0;
    ref_mem = mem;
    pcv = RESET_PC;
    exp_n = 0;
    exp_halt_pc = 32'hFFFF_FFFF;
    for (int step = 0; step < 4000; step++) begin
      ins = ref_mem[pcv[11:2]];
      sx  = {{16{ins[15]}}, ins[15:0]};
      npc = pcv + 32'd4;
      ill = 0;
      lat = 4;
      v   = '0;
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h21: v = r[ins[25:21]] + r[ins[20:16]];
            6'h23: v = r[ins[25:21]] - r[ins[20:16]];
            6'h24: v = r[ins[25:21]] & r[ins[20:16]];
            6'h25: v = r[ins[25:21]] | r[ins[20:16]];
            6'h2A: v = ($signed(r[ins[25:21]]) < $signed(r[ins[20:16]])) ? 32'd1 : 32'd0;
            default: ill = 1;
          endcase
          if (!ill) r[ins[15:11]] = v;
        end
        6'h09: r[ins[20:16]] = r[ins[25:21]] + sx;
        6'h0D: r[ins[20:16]] = r[ins[25:21]] | {16'h0, ins[15:0]};
        6'h0F: r[ins[20:16]] = {ins[15:0], 16'h0};
        6'h23: begin
          ea = r[ins[25:21]] + sx;
          r[ins[20:16]] = ref_mem[ea[11:2]];
          lat = 5;
        end
        6'h2B: begin
          ea = r[ins[25:21]] + sx;
          st_q.push_back('{ea[11:2], r[ins[20:16]]});
          ref_mem[ea[11:2]] = r[ins[20:16]];
        end
        6'h04: begin
          if (r[ins[25:21]] == r[ins[20:16]]) npc = npc + (sx << 2);
          lat = 3;
        end
        6'h02: begin
          npc = {npc[31:28], ins[25:0], 2'b00};
          lat = 2;
        end
        default: ill = 1;
      endcase
      if (ill) begin
        exp_halt_pc = pcv;
        return;
      end
      ret_q.push_back('{pcv, lat, exp_n});
      exp_n++;
      r[0] = '0;
      pcv = npc;
    end
  endtask

  task automatic gen_random(input int variant);
    logic [5:0] fns [5];
    int t, mx;
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
    for (int w = 0; w < 1024; w++) mem[w] = $urandom;
    for (int k = 1; k < 8; k++) mem[k-1] = enc_i(6'h0D, 0, k, int'($urandom_range(0, 65535)));
    for (int w = 7; w < 47; w++) begin
      t = int'($urandom_range(0, 9));
      case (t)
        0, 1, 2: mem[w] = enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]);
        3: mem[w] = enc_i(6'h09, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
        4: mem[w] = enc_i(6'h0D, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
        5: mem[w] = enc_i(6'h0F, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
        6: mem[w] = enc_i(6'h23, 0, int'($urandom_range(0, 7)), 1024 + 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3)));
        7: mem[w] = enc_i(6'h2B, 0, int'($urandom_range(0, 7)), 1024 + 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3)));
        8: begin
          mx = 46 - w;
          if (mx > 3) mx = 3;
          t = int'($urandom_range(0, 7));
          mem[w] = enc_i(6'h04, t, ($urandom_range(0, 1) == 1) ? t : int'($urandom_range(0, 7)),
                         int'($urandom_range(0, mx)));
        end
        default: begin
          mx = w + 4;
          if (mx > 47) mx = 47;
          mem[w] = enc_j(int'($urandom_range(w + 1, mx)));
        end
      endcase
    end
    for (int k = 0; k < 8; k++) mem[47+k] = enc_i(6'h2B, 0, k, 2048 + 4 * k);
    case (variant)
      0:       mem[55] = {6'h3F, 26'h0};
      1:       mem[55] = enc_r(1, 2, 3, 6'h00);
      default: mem[55] = enc_i(6'h08, 1, 2, 3);
    endcase
  endtask

  task automatic load_directed();
    for (int w = 0; w < 1024; w++) mem[w] = {6'h3F, 26'h0};
    mem[0]  = enc_i(6'h0D, 0, 1, 5);
    mem[1]  = enc_i(6'h0D, 0, 2, 3);
    mem[2]  = enc_r(1, 2, 3, 6'h21);
    mem[3]  = enc_r(2, 1, 4, 6'h23);
    mem[4]  = enc_i(6'h2B, 0, 3, 8);
    mem[5]  = enc_i(6'h23, 0, 5, 8);
    mem[6]  = enc_i(6'h2B, 0, 5, 16);
    mem[7]  = enc_i(6'h2B, 0, 4, 20);
    mem[8]  = enc_i(6'h04, 1, 2, 1);
    mem[9]  = enc_j(16);
    mem[16] = enc_r(1, 1, 0, 6'h21);
    mem[17] = enc_i(6'h2B, 0, 0, 24);
    mem[18] = enc_r(4, 1, 6, 6'h2A);
    mem[19] = enc_i(6'h2B, 0, 6, 28);
    mem[20] = enc_i(6'h04, 0, 0, 1);
    mem[22] = enc_i(6'h0F, 0, 7, 16'hABCD);
    mem[23] = enc_i(6'h0D, 7, 7, 16'h1234);
    mem[24] = enc_i(6'h2B, 0, 7, 32);
  endtask

  // Memory model: random wait states, checks request stability and stores.
  initial begin : mem_model
    bit          busy;
    int          wl;
    logic [9:0]  la;
    logic        lwe;
    logic [31:0] lwd;
    st_t         s;
    busy = 0;
    wl = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_mode == 2) begin
        mem_ack = 1'b1;
        mem_rdata = enc_j(64);
      end else if (mem_mode == 0 && mem_req) begin
        if (!busy) begin
          busy = 1;
          wl = int'($urandom_range(0, max_wait));
          la = mem_addr; lwe = mem_we; lwd = mem_wdata;
        end else begin
          check("hold_addr", 32'(mem_addr), 32'(la));
          check("hold_we", 32'(mem_we), 32'(lwe));
          if (lwe) check("hold_wdata", mem_wdata, lwd);
        end
        if (wl == 0) begin
          mem_ack = 1'b1;
          busy = 0;
          if (mem_we) begin
            if (st_q.size() == 0) begin
              total++; bad++;
              $display("FAIL store_unexpected: got addr %h data %h expected none", mem_addr, mem_wdata);
            end else begin
              s = st_q.pop_front();
              check("store_addr", 32'(mem_addr), 32'(s.addr));
              check("store_data", mem_wdata, s.data);
            end
            mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
            last_rd_ack = gcyc + 1;
          end
        end else begin
          wl--;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Retire monitor: pc, retire index and latency net of memory waits.
  initial begin : monitor
    int   cyc, waits;
    bit   prev_halted;
    ret_t e;
    cyc = 0; waits = 0; prev_halted = 0;
    forever begin
      @(negedge clk);
      #1;
      gcyc++;
      if (rst) begin
        cyc = 0; waits = 0; prev_halted = 0;
      end else begin
        cyc++;
        if (mem_req && !mem_ack) waits++;
        if (retire) begin
          if (ret_q.size() == 0) begin
            total++; bad++;
            $display("FAIL retire_unexpected: got retire at pc %h expected none", pc_o);
          end else begin
            e = ret_q.pop_front();
            check("retire_pc", pc_o, e.pc);
            check("retire_cnt", retire_cnt, 32'(e.cnt));
            check("latency", 32'(cyc - waits), 32'(e.lat));
          end
          cyc = 0; waits = 0;
        end
        if (halted && !prev_halted) check("halt_delay", 32'(gcyc - last_rd_ack), 32'd2);
        prev_halted = halted;
      end
    end
  end

  task automatic assert_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", pc_o, RESET_PC);
    check("rst_cnt", retire_cnt, 32'd0);
  endtask

  task automatic start_program(input int mw);
    max_wait = mw;
    ret_q.delete();
    st_q.delete();
    ref_run();
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_to_halt();
    for (int i = 0; i < 20000 && !halted; i++) @(negedge clk);
    #2;
    check("halted", 32'(halted), 32'd1);
    check("halt_pc", pc_o, exp_halt_pc);
    check("halt_cnt", retire_cnt, 32'(exp_n));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check("halt_quiet", {30'b0, mem_req, retire}, 32'd0);
    end
    check("ret_q_left", 32'(ret_q.size()), 32'd0);
    check("st_q_left", 32'(st_q.size()), 32'd0);
  endtask

  initial begin : main
    int n;
    // Directed program, zero-wait memory.
    assert_reset();
    load_directed();
    start_program(0);
    repeat (16) @(posedge clk);
    #2 check("cnt_after_16", retire_cnt, 32'd4);
    run_to_halt();

    // Random program with up to 3 wait cycles per access.
    assert_reset();
    gen_random(0);
    start_program(3);
    run_to_halt();

    // Reset while FETCH is waiting for an ack; a forced ack during reset is ignored.
    assert_reset();
    gen_random(1);
    start_program(1);
    n = 0;
    while (n < 5000 && !(retire && retire_cnt >= 32'd5)) begin
      @(negedge clk); #2;
      n++;
    end
    check("mid_run_reached", 32'(n < 5000), 32'd1);
    mem_mode = 1;
    @(negedge clk); #2;
    check("fetch_wait_req", 32'(mem_req), 32'd1);
    check("fetch_wait_we", 32'(mem_we), 32'd0);
    rst = 1'b1;
    mem_mode = 2;
    @(negedge clk); #2;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_pc", pc_o, RESET_PC);
    check("rst_mid_cnt", retire_cnt, 32'd0);
    @(negedge clk); #2;
    mem_mode = 0;

    // Fresh program after the interrupted one; first retire must be from RESET_PC.
    gen_random(2);
    start_program(2);
    run_to_halt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
